cross_bar_slave_sched: RTL and testbench
========================================

# cross_bar_slave_sched

Per-slave transaction scheduler for the crossbar: shares one slave port between `MASTER_N` masters by granting whole bursts in round-robin order. It locks the grant for the requested number of data beats and rotates priority only at burst boundaries, so a burst is never interleaved. One instance sits in front of each slave mux and drives that mux's select.

## Interface
- `MASTER_N`, default `cross_bar_pkg::MASTER_N` (4): number of requesting masters.
- `LEN_W`, default 8: burst length field width. The length is encoded as beats−1.
- `TIMEOUT`, default 256: stall-watchdog limit in cycles. Used only with `CROSS_BAR_SCHED_TIMEOUT_EN`.
- `clk` in, 1: single clock. All logic is rising-edge.
- `rst` in, 1: reset, synchronous and active-high.
- `req` in, MASTER_N: per-master burst request, level-sensitive.
- `req_len` in, MASTER_N*LEN_W: per-master burst length (beats−1). Master m occupies bits [m*LEN_W +: LEN_W].
- `beat_valid` in, 1: valid from the granted master's datapath.
- `beat_ready` in, 1: ready from the slave. A beat is accepted when `beat_valid` and `beat_ready` are both high.
- `grant` out, MASTER_N: one-hot or zero, registered.
- `grant_id` out, $clog2(MASTER_N): binary index of the granted master, registered. Valid while `busy` is high.
- `busy` out, 1: high in ACTIVE.
- `beat_last` out, 1: high in ACTIVE when the remaining count is 0 (the current beat is the last one).
- `timeout_pulse` out, 1: one-cycle pulse when the watchdog releases a grant.

## Operation
- **Reset values:** state IDLE, `grant`=0, `grant_id`=0, `busy`=0, `beat_last`=0, `timeout_pulse`=0, priority pointer `ptr`=0, beat counter=0, watchdog=0.
- **IDLE:** if `req`≠0, select the first requester found scanning from `ptr` upward with wrap-around. On that edge:
  - `grant` and `grant_id` are registered.
  - The counter loads `req_len[winner]`.
  - `ptr` becomes (winner+1) mod MASTER_N.
  - State moves to ACTIVE.
- **ACTIVE:** the counter decrements on each accepted beat. An accepted beat with counter=0 is the last beat: next edge clears `grant` and `busy` and returns to IDLE.
- **Lock:** `req` and `req_len` are ignored in ACTIVE. Deasserting the granted `req` mid-burst does not release the grant.
- A `req_len` change after the grant has no effect on the current burst.
- `beat_valid` without `beat_ready`, or `beat_ready` without `beat_valid`, does not change the counter.
- **Maximum burst:** `req_len`=all ones gives 2^LEN_W beats. The counter never wraps below 0.
- **Reset mid-burst:** `rst` high in ACTIVE aborts the burst. All outputs take reset values on that edge and `ptr` returns to 0.

## Timing
- **Grant latency:** a `req` visible before edge N in IDLE produces `grant` high from edge N onward (1 cycle).
- **Release:** the last beat is accepted at edge K. `grant` is 0 during cycle K..K+1.
  - The next grant appears at edge K+1, so there is exactly one idle cycle between bursts.
  - A burst of L+1 beats with `beat_ready` held high occupies the slave for L+2 cycles including the gap.
- `beat_last` is combinational from the state and counter, and is valid in the same cycle as the final beat.
- `grant` and `grant_id` always change on the same edge. `grant` is never multi-hot.

## Configuration
- **`CROSS_BAR_SCHED_TIMEOUT_EN` defined:**
  - The watchdog counts ACTIVE cycles with no accepted beat, and clears on every accepted beat.
  - When it reaches TIMEOUT−1 the grant is released on the next edge, as for a last beat, and `timeout_pulse`=1 for that one cycle.
  - `ptr` keeps the value it was given at grant time.
- **Not defined:** no watchdog logic is built, `timeout_pulse` is tied to 0, and a stalled burst holds the grant indefinitely.

## Structure
- `cross_bar_pkg` gains the state enum `sched_state_t` {IDLE, ACTIVE}, the constant `GRANT_ID_W = $clog2(MASTER_N)`, and the default `SCHED_TIMEOUT`.
- The existing `MASTER_N` is reused from the same package.
- Sub-module `cross_bar_rr_pick`: a combinational rotating-priority picker with inputs `req` and `ptr`, and outputs one-hot `pick`, `pick_id` and `any`.
- The FSM, counter, pointer and watchdog live in the top level.

## Test plan
- **Reset:** assert `rst` 3 cycles, then `req`=4'b1111. Every output is 0 while in reset. Asserting `rst` mid-burst zeroes `grant` at the next edge, and the next grant goes to master 0.
- **Single burst:** `req[2]`=1, `req_len`[2]=3, `beat_ready` and `beat_valid` held high.
  - `grant`=4'b0100 and `grant_id`=2 one cycle after `req`.
  - The grant holds for exactly 4 beats, with `beat_last` on the 4th.
  - `grant`=0 on the following cycle.
- **Full rotation:** `req`=4'b1111, all lengths 0, always accepting.
  - The grant sequence is 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 1 cycle, separated by 1 idle cycle.
- **Skip and wrap:** with `ptr`=2 and `req`=4'b1010, master 3 is granted first, then master 1.
- **Backpressure:** `req_len`=2 with `beat_ready` pattern 1,0,0,1,0,1. The grant is held for 6 cycles, `beat_last` goes high after the 2nd accepted beat, and release follows the 3rd.
- **Watchdog:** `TIMEOUT`=16 with no beats after the grant.
  - With the macro: `grant` drops 16 cycles after the grant edge, `timeout_pulse` is high for exactly 1 cycle, and the next requester is granted one cycle later.
  - Without the macro: the grant is still held after 1000 cycles.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// ============================================================================
// Module  : cross_bar_pkg
// Brief   : Shared crossbar constants and the slave scheduler state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cross_bar_pkg;

    localparam int MASTER_N      = 4;
    localparam int GRANT_ID_W    = $clog2(MASTER_N);
    localparam int SCHED_TIMEOUT = 256;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/cross_bar_rr_pick.sv
// ============================================================================
// Module  : cross_bar_rr_pick
// Brief   : Combinational rotating-priority picker; first requester at or
//           above ptr wins, wrapping around.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cross_bar_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    pick,
    output logic [ID_W-1:0] pick_id,
    output logic            any
);

    int w_idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (int'(ptr) + i) % N;
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                pick[w_idx]  = 1'b1;
                pick_id      = ID_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cross_bar_slave_sched.sv
// ============================================================================
// Module  : cross_bar_slave_sched
// Brief   : Per-slave round-robin burst scheduler; grants whole bursts and
//           rotates priority only at burst boundaries. Optional stall
//           watchdog enabled by `CROSS_BAR_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cross_bar_slave_sched #(
    parameter int MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int LEN_W    = 8,
    parameter int TIMEOUT  = cross_bar_pkg::SCHED_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MASTER_N-1:0]         req,
    input  logic [MASTER_N*LEN_W-1:0]   req_len,
    input  logic                        beat_valid,
    input  logic                        beat_ready,
    output logic [MASTER_N-1:0]         grant,
    output logic [$clog2(MASTER_N)-1:0] grant_id,
    output logic                        busy,
    output logic                        beat_last,
    output logic                        timeout_pulse
);

    import cross_bar_pkg::*;

    localparam int c_ID_W = $clog2(MASTER_N);

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("TIMEOUT must be at least 2");
    end

    sched_state_t          r_state, w_state_nxt;
    logic [MASTER_N-1:0]   r_grant, w_grant_nxt;
    logic [c_ID_W-1:0]     r_grant_id, w_grant_id_nxt;
    logic [c_ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic [LEN_W-1:0]      r_cnt, w_cnt_nxt;

    logic [MASTER_N-1:0]   w_pick;
    logic [c_ID_W-1:0]     w_pick_id;
    logic                  w_any;
    logic                  w_accept;
    logic [LEN_W-1:0]      w_len [MASTER_N];

    for (genvar m = 0; m < MASTER_N; m++) begin : g_len
        assign w_len[m] = req_len[m*LEN_W +: LEN_W];
    end

    cross_bar_rr_pick #(
        .N    (MASTER_N),
        .ID_W (c_ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .pick    (w_pick),
        .pick_id (w_pick_id),
        .any     (w_any)
    );

    assign w_accept = beat_valid && beat_ready;

`ifdef CROSS_BAR_SCHED_TIMEOUT_EN
    localparam int              c_WD_W     = $clog2(TIMEOUT);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT - 1);

    logic [c_WD_W-1:0] r_wdog, w_wdog_nxt;
    logic              r_tpulse, w_tpulse_nxt;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
`ifdef CROSS_BAR_SCHED_TIMEOUT_EN
        w_wdog_nxt     = r_wdog;
        w_tpulse_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt    = ACTIVE;
                    w_grant_nxt    = w_pick;
                    w_grant_id_nxt = w_pick_id;
                    w_cnt_nxt      = w_len[w_pick_id];
                    w_ptr_nxt      = (int'(w_pick_id) == MASTER_N - 1) ? '0 : w_pick_id + 1'b1;
`ifdef CROSS_BAR_SCHED_TIMEOUT_EN
                    w_wdog_nxt     = '0;
`endif
                end
            end
            ACTIVE: begin
                if (w_accept) begin
`ifdef CROSS_BAR_SCHED_TIMEOUT_EN
                    w_wdog_nxt = '0;
`endif
                    // Counter holds beats-1, so zero here means this is the final beat
                    if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
`ifdef CROSS_BAR_SCHED_TIMEOUT_EN
                else if (r_wdog == c_WD_LIMIT) begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_wdog_nxt   = '0;
                    w_tpulse_nxt = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

`ifdef CROSS_BAR_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog   <= '0;
            r_tpulse <= 1'b0;
        end else begin
            r_wdog   <= w_wdog_nxt;
            r_tpulse <= w_tpulse_nxt;
        end
    end

    assign timeout_pulse = r_tpulse;
`else
    assign timeout_pulse = 1'b0;
`endif

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == ACTIVE);
    assign beat_last = (r_state == ACTIVE) && (r_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_cross_bar_slave_sched.sv
// ============================================================================
// Module  : tb_cross_bar_slave_sched
// Brief   : Scoreboard bench for cross_bar_slave_sched; a burst-level model
//           predicts outputs, a monitor compares every cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cross_bar_slave_sched;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int TO = 16;
`ifdef CROSS_BAR_SCHED_TIMEOUT_EN
    localparam bit c_WD_ON    = 1'b1;
    localparam int c_STALL_N  = 25;
`else
    localparam bit c_WD_ON    = 1'b0;
    localparam int c_STALL_N  = 1000;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic            beat_valid;
    logic            beat_ready;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            busy;
    logic            beat_last;
    logic            timeout_pulse;

    cross_bar_slave_sched #(
        .MASTER_N (N),
        .LEN_W    (LW),
        .TIMEOUT  (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_len       (req_len),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .grant         (grant),
        .grant_id      (grant_id),
        .busy          (busy),
        .beat_last     (beat_last),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   id;
        logic         chk_id;
        logic         busy;
        logic         last;
        logic         pulse;
    } exp_t;

    exp_t scb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    // Reference model: who owns the slave and how many beats remain
    int   len_a [N];
    bit   m_active = 1'b0;
    int   m_owner  = 0;
    int   m_rem    = 0;
    int   m_next   = 0;
    int   m_stall  = 0;
    bit   m_pulse  = 1'b0;

    task automatic model_step(input logic rs, input logic [N-1:0] r, input logic acc);
        exp_t e;
        m_pulse = 1'b0;
        if (rs) begin
            m_active = 1'b0; m_owner = 0; m_rem = 0; m_next = 0; m_stall = 0;
        end else if (!m_active) begin
            if (r != '0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_next + k) % N;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_active = 1'b1;
                m_rem    = len_a[m_owner] + 1;
                m_next   = (m_owner + 1) % N;
                m_stall  = 0;
            end
        end else if (acc) begin
            m_rem   = m_rem - 1;
            m_stall = 0;
            if (m_rem == 0) m_active = 1'b0;
        end else begin
            m_stall = m_stall + 1;
            if (c_WD_ON && m_stall == TO) begin
                m_active = 1'b0;
                m_pulse  = 1'b1;
            end
        end
        e.grant  = m_active ? (N'(1) << m_owner) : '0;
        e.id     = 2'(m_owner);
        e.chk_id = m_active || rs;
        e.busy   = m_active;
        e.last   = m_active && (m_rem == 1);
        e.pulse  = m_pulse;
        scb.push_back(e);
    endtask

    task automatic cyc(input logic rs, input logic [N-1:0] r, input logic v, input logic rd);
        rst        = rs;
        req        = r;
        beat_valid = v;
        beat_ready = rd;
        for (int m = 0; m < N; m++) req_len[m*LW +: LW] = LW'(len_a[m]);
        model_step(rs, r, v && rd);
        @(negedge clk);
    endtask

    task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
        len_a[0] = l0; len_a[1] = l1; len_a[2] = l2; len_a[3] = l3;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            n_vec++;
            if (scb.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty t=%0t got grant=%b with no expected entry", $time, grant);
            end else begin
                e = scb.pop_front();
                if (grant !== e.grant || busy !== e.busy || beat_last !== e.last ||
                    timeout_pulse !== e.pulse || (e.chk_id && grant_id !== e.id)) begin
                    n_err++;
                    $display("FAIL cycle_outputs t=%0t got grant=%b id=%0d busy=%b last=%b to=%b want grant=%b id=%0d busy=%b last=%b to=%b",
                             $time, grant, grant_id, busy, beat_last, timeout_pulse,
                             e.grant, e.id, e.busy, e.last, e.pulse);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rr;
        logic         vv, rd, rs;
        set_lens(0, 0, 0, 0);

        // Reset held with all masters requesting, then a full rotation
        repeat (3) cyc(1'b1, 4'b1111, 1'b1, 1'b1);
        repeat (10) cyc(1'b0, 4'b1111, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 4'b0000, 1'b0, 1'b0);

        // Single 4-beat burst on master 2, request dropped after grant
        set_lens(0, 0, 3, 0);
        cyc(1'b0, 4'b0100, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 4'b0000, 1'b1, 1'b1);

        // Move ptr to 2 via master 1, then skip-and-wrap with 1010
        set_lens(0, 0, 0, 0);
        cyc(1'b0, 4'b0010, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 4'b1010, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 4'b0000, 1'b0, 1'b0);

        // Backpressure: 3-beat burst, ready pattern 1,0,0,1,0,1
        set_lens(2, 0, 0, 0);
        cyc(1'b0, 4'b0001, 1'b0, 1'b0);
        foreach (rr[i]) begin end
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 4'b0000, 1'b0, 1'b0);

        // Reset mid-burst, then the next grant must start from master 0
        set_lens(0, 0, 10, 0);
        cyc(1'b0, 4'b0100, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 4'b0100, 1'b1, 1'b1);
        cyc(1'b1, 4'b1111, 1'b1, 1'b1);
        set_lens(0, 0, 0, 0);
        repeat (4) cyc(1'b0, 4'b1111, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 4'b0000, 1'b0, 1'b0);

        // Stalled burst: watchdog release, or indefinite hold without it
        set_lens(5, 0, 0, 0);
        repeat (c_STALL_N) cyc(1'b0, 4'b0011, 1'b0, 1'b0);
        repeat (12) cyc(1'b0, 4'b0011, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 4'b0000, 1'b0, 1'b0);

        // Maximum burst length on one master
        set_lens(0, 0, 0, 255);
        cyc(1'b0, 4'b1000, 1'b1, 1'b1);
        repeat (258) cyc(1'b0, 4'b0000, 1'b1, 1'b1);

        // Randomized traffic with length changes, stall windows and rare resets
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < N; m++)
                len_a[m] = ($urandom_range(0, 39) == 0) ? 255 : int'($urandom_range(0, 3));
            rr = N'($urandom_range(0, 15));
            vv = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 7);
            if ((i % 300) >= 270) vv = 1'b0;
            rs = ($urandom_range(0, 499) == 0);
            cyc(rs, rr, vv, rd);
        end

        done = 1'b1;
        #20;
        if (scb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", scb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
